// File: rtl/ctr_block_feeder_pkg.sv
// Shared types and lane helpers for the CTR block feeder.
// Lane i of a block occupies bits [127-8i -: 8]; keep bit 15 maps to lane 0.
package ctr_feed_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef enum logic [1:0] {FILL, START, WAIT, OUT} state_t;

  function automatic int lane_off(input int lane);
    return 127 - 8 * lane;
  endfunction

  function automatic logic [127:0] keep_mask(input logic [15:0] keep);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < BLOCK_BYTES; i++)
      m[lane_off(i) -: 8] = {8{keep[15-i]}};
    return m;
  endfunction

endpackage

// File: rtl/ctr_block_feeder_if.sv
// Byte stream in, encryptor handshake and ciphertext block out for the CTR feeder.
// master = the feeder, slave = its surroundings (source, encryptor, sink).
interface ctr_block_feeder_if #(parameter int CNT_W = 32);
  logic [7:0]       s_byte;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             enc_start;
  logic [127:0]     enc_block;
  logic             enc_done;
  logic [127:0]     enc_result;
  logic [127:0]     m_block;
  logic [15:0]      m_keep;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] blk_count;
  logic             err;

  modport master (
    input  s_byte, s_valid, s_last, enc_done, enc_result, m_ready,
    output s_ready, enc_start, enc_block, m_block, m_keep, m_last, m_valid,
           blk_count, err
  );

  modport slave (
    output s_byte, s_valid, s_last, enc_done, enc_result, m_ready,
    input  s_ready, enc_start, enc_block, m_block, m_keep, m_last, m_valid,
           blk_count, err
  );
endinterface

// File: rtl/ctr_block_feeder.sv
// Packs plaintext bytes into 128-bit blocks, drives the CTR encryptor and emits
// masked ciphertext blocks. Define CTR_FEED_TIMEOUT_EN to abort stalled encryptions.
module ctr_block_feeder
  import ctr_feed_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  ctr_block_feeder_if.master bus
);

  state_t           r_state;
  logic [3:0]       r_byte_cnt;
  logic [127:0]     r_enc_block;
  logic [15:0]      r_keep;
  logic             r_last;
  logic [127:0]     r_m_block;
  logic             r_m_valid;
  logic             r_enc_start;
  logic             r_s_ready;
  logic [CNT_W-1:0] r_blk_count;
  logic [6:0]       w_lane_off;

  assign w_lane_off = 7'(lane_off(int'(r_byte_cnt)));

`ifdef CTR_FEED_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;
  assign bus.err = r_err;
`else
  // No watchdog in this build; err is a constant-false expression.
  assign bus.err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FILL;
      r_byte_cnt  <= '0;
      r_enc_block <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
      r_m_block   <= '0;
      r_m_valid   <= 1'b0;
      r_enc_start <= 1'b0;
      r_s_ready   <= 1'b0;
      r_blk_count <= '0;
`ifdef CTR_FEED_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_enc_start <= 1'b0;
      case (r_state)
        FILL: begin
          r_s_ready <= 1'b1;
          if (bus.s_valid && r_s_ready) begin
            r_enc_block[w_lane_off -: 8] <= bus.s_byte;
            r_keep[4'd15 - r_byte_cnt]   <= 1'b1;
            r_last                       <= bus.s_last;
            if (r_byte_cnt == 4'd15 || bus.s_last) begin
              r_byte_cnt  <= '0;
              r_s_ready   <= 1'b0;
              r_enc_start <= 1'b1;
              r_state     <= START;
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
            end
          end
        end
        START: begin
`ifdef CTR_FEED_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.enc_done) begin
            r_m_block <= bus.enc_result & keep_mask(r_keep);
            r_m_valid <= 1'b1;
            r_state   <= OUT;
          end
`ifdef CTR_FEED_TIMEOUT_EN
          else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up on this block: drop it silently and flag the stall.
            r_err       <= 1'b1;
            r_enc_block <= '0;
            r_keep      <= '0;
            r_last      <= 1'b0;
            r_s_ready   <= 1'b1;
            r_state     <= FILL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        OUT: begin
          if (bus.m_ready) begin
            r_m_valid   <= 1'b0;
            r_blk_count <= r_blk_count + 1'b1;
            r_enc_block <= '0;
            r_keep      <= '0;
            r_last      <= 1'b0;
            r_s_ready   <= 1'b1;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.enc_start = r_enc_start;
  assign bus.enc_block = r_enc_block;
  assign bus.m_block   = r_m_block;
  assign bus.m_keep    = r_keep;
  assign bus.m_last    = r_last;
  assign bus.m_valid   = r_m_valid;
  assign bus.blk_count = r_blk_count;

endmodule

// File: tb/tb_ctr_block_feeder.sv
// Randomized bench for ctr_block_feeder: messages are chunked into expected blocks
// by plain arithmetic, and an inline encryptor stand-in answers each start.
module tb_ctr_block_feeder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctr_block_feeder_if #(.CNT_W(32)) bus ();

  ctr_block_feeder #(.CNT_W(32), .TIMEOUT_CYCLES(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enc_block"}, bus.enc_block, '0);
    chk({tag, "_m_block"},   bus.m_block,   '0);
    chk({tag, "_m_keep"},    128'(bus.m_keep), '0);
    chk({tag, "_m_last"},    128'(bus.m_last), '0);
    chk({tag, "_m_valid"},   128'(bus.m_valid), '0);
    chk({tag, "_enc_start"}, 128'(bus.enc_start), '0);
    chk({tag, "_blk_count"}, 128'(bus.blk_count), '0);
    chk({tag, "_err"},       128'(bus.err), '0);
  endtask

  // Sends one message; checks every block it produces. Starts and ends at posedge+1.
  task automatic run_msg(input logic [7:0] msg[$], input int dly, input int hold,
                         input bit rnd_res);
    int pos;
    pos = 0;
    while (pos < msg.size()) begin
      int           n;
      bit           last;
      logic [127:0] pb, mask, res;
      logic [15:0]  keep;
      n    = (msg.size() - pos > 16) ? 16 : msg.size() - pos;
      last = (pos + n == msg.size());
      pb = '0; mask = '0; keep = '0;
      for (int i = 0; i < n; i++) begin
        pb   |= 128'(msg[pos+i]) << (8 * (15 - i));
        mask |= 128'hFF << (8 * (15 - i));
        keep |= 16'h8000 >> i;
      end
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.s_valid = 1'b0;
          @(negedge clk);
          chk("s_ready_gap", 128'(bus.s_ready), 1);
          step();
        end
        bus.s_valid = 1'b1;
        bus.s_byte  = msg[pos+i];
        bus.s_last  = (pos + i == msg.size() - 1);
        @(negedge clk);
        chk("s_ready_fill", 128'(bus.s_ready), 1);
        chk("no_early_start", 128'(bus.enc_start), 0);
        step();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      @(negedge clk);
      chk("enc_start", 128'(bus.enc_start), 1);
      chk("s_ready_start", 128'(bus.s_ready), 0);
      chk("enc_block", bus.enc_block, pb);
      step();
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        chk("start_once", 128'(bus.enc_start), 0);
        chk("s_ready_wait", 128'(bus.s_ready), 0);
        chk("m_valid_wait", 128'(bus.m_valid), 0);
        chk("enc_block_hold", bus.enc_block, pb);
        step();
      end
      res = rnd_res ? {$urandom, $urandom, $urandom, $urandom} : {128{1'b1}};
      bus.enc_done   = 1'b1;
      bus.enc_result = res;
      step();
      bus.enc_done   = 1'b0;
      bus.enc_result = {$urandom, $urandom, $urandom, $urandom};
      for (int h = 0; h <= hold; h++) begin
        @(negedge clk);
        chk("m_valid", 128'(bus.m_valid), 1);
        chk("m_block", bus.m_block, res & mask);
        chk("m_keep", 128'(bus.m_keep), 128'(keep));
        chk("m_last", 128'(bus.m_last), 128'(last));
        chk("s_ready_out", 128'(bus.s_ready), 0);
        step();
      end
      bus.m_ready = 1'b1;
      @(negedge clk);
      chk("m_valid_hs", 128'(bus.m_valid), 1);
      step();
      bus.m_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      chk("m_valid_drop", 128'(bus.m_valid), 0);
      chk("blk_count", 128'(bus.blk_count), 128'(exp_cnt));
      chk("s_ready_refill", 128'(bus.s_ready), 1);
      step();
      pos += n;
    end
  endtask

  task automatic feed_short(input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_byte  = 8'($urandom);
      bus.s_last  = (i == n - 1);
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    bus.s_byte = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.enc_done = 1'b0; bus.enc_result = '0; bus.m_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    chk("rst_s_ready", 128'(bus.s_ready), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("s_ready_pre", 128'(bus.s_ready), 0);
    step();
    @(negedge clk);
    chk("s_ready_post", 128'(bus.s_ready), 1);
    step();

    // Full block 00..0F, all-ones result
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    run_msg(q, 5, 0, 1'b0);

    // Short block A1..A5
    q = {};
    for (int i = 1; i <= 5; i++) q.push_back(8'hA0 + 8'(i));
    run_msg(q, 5, 0, 1'b0);

    // 40 bytes -> 16,16,8
    q = {};
    for (int i = 0; i < 40; i++) q.push_back(8'($urandom));
    run_msg(q, 5, 0, 1'b1);

    // Downstream stall for 10 cycles
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    run_msg(q, 3, 10, 1'b1);

    // Random messages
    for (int m = 0; m < 6; m++) begin
      int len;
      len = $urandom_range(1, 48);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_msg(q, $urandom_range(1, 8), $urandom_range(0, 3), 1'b1);
    end

    // Stray done while idle in FILL
    bus.enc_done = 1'b1;
    bus.enc_result = '1;
    step();
    bus.enc_done = 1'b0;
    @(negedge clk);
    chk("stray_m_valid", 128'(bus.m_valid), 0);
    chk("stray_s_ready", 128'(bus.s_ready), 1);
    step();
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
    run_msg(q, 4, 1, 1'b1);

    // Reset asserted asynchronously in WAIT, then a late done
    feed_short(3);
    @(negedge clk);
    chk("rw_enc_start", 128'(bus.enc_start), 1);
    step();
    step();
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_wait");
    chk("rst_wait_s_ready", 128'(bus.s_ready), 0);
    step();
    reset = 1'b0;
    exp_cnt = 0;
    bus.enc_done = 1'b1;
    bus.enc_result = '1;
    step();
    bus.enc_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("late_done_m_valid", 128'(bus.m_valid), 0);
      step();
    end
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    run_msg(q, 2, 0, 1'b1);

    // Encryptor never answers
    feed_short(2);
    @(negedge clk);
    chk("to_enc_start", 128'(bus.enc_start), 1);
    step();
`ifdef CTR_FEED_TIMEOUT_EN
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      chk("to_m_valid", 128'(bus.m_valid), 0);
      if (k == 64) chk("to_err_early", 128'(bus.err), 0);
      if (k == 65) begin
        chk("to_err", 128'(bus.err), 1);
        chk("to_s_ready", 128'(bus.s_ready), 1);
        chk("to_blk_count", 128'(bus.blk_count), 128'(exp_cnt));
      end
      step();
    end
    repeat (3) step();
    @(negedge clk);
    chk("to_err_sticky", 128'(bus.err), 1);
    chk("to_m_valid_end", 128'(bus.m_valid), 0);
    step();
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    run_msg(q, 2, 0, 1'b1);
`else
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      chk("nodone_m_valid", 128'(bus.m_valid), 0);
      chk("nodone_s_ready", 128'(bus.s_ready), 0);
      step();
    end
    @(negedge clk);
    chk("nodone_err", 128'(bus.err), 0);
    chk("nodone_blk_count", 128'(bus.blk_count), 128'(exp_cnt));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
